// File: rtl/pe_row_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pe_row_ctrl: LSTM-mode sequencer for a row of 8-bit MAC PEs            |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module pe_row_ctrl #(
    parameter int NUM_PE    = 4,
    parameter int ADDR_W    = 8,
    parameter int OUT_BQ_DW = 32
) (
    input  logic                 wclk,
    input  logic                 rst_n,
    input  logic [3:0]           seg_state,
    input  logic                 start,
    input  logic                 mode,
    input  logic [ADDR_W-1:0]    vec_len,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           mult_int8_crl,
    output logic [ADDR_W-1:0]    spad_addr,
    output logic                 spad_rd_en,
    output logic                 had_rd_en,
    input  logic [OUT_BQ_DW-1:0] tail_out,
    output logic [OUT_BQ_DW-1:0] res_data,
    output logic                 res_valid,
    input  logic                 res_ready
);

    localparam logic [3:0] SEG_LSTM  = 4'b0010;
    localparam logic [2:0] CRL_RST   = 3'b000;
    localparam logic [2:0] CRL_MAC   = 3'b001;
    localparam logic [2:0] CRL_XFER  = 3'b011;
    localparam logic [2:0] CRL_HOLD  = 3'b111;
    localparam logic [2:0] CRL_HAD   = 3'b010;
    localparam int         SCNT_W    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(NUM_PE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAC   = 3'd1,
        S_HAD   = 3'd2,
        S_SHIFT = 3'd3,
        S_CLR   = 3'd4
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]   len_q;
    logic [SCNT_W-1:0]   scnt_q;
    logic [2:0]          crl_q;
    logic                busy_q;
    logic                done_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                spad_rd_q;
    logic                had_rd_q;
    logic                valid_q;
    logic [ADDR_W:0]     cnt_d;

    // One bit wider so that vec_len = 2^ADDR_W-1 cannot wrap the compare.
    assign cnt_d = {1'b0, cnt_q} + 1'b1;

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            scnt_q    <= '0;
            crl_q     <= CRL_RST;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            spad_rd_q <= 1'b0;
            had_rd_q  <= 1'b0;
            valid_q   <= 1'b0;
        end else if (state_q != S_IDLE && seg_state != SEG_LSTM) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            scnt_q    <= '0;
            crl_q     <= CRL_RST;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            spad_rd_q <= 1'b0;
            had_rd_q  <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    crl_q  <= CRL_RST;
                    done_q <= 1'b0;
                    if (start && seg_state == SEG_LSTM) begin
                        len_q  <= vec_len;
                        cnt_q  <= '0;
                        scnt_q <= '0;
                        busy_q <= 1'b1;
                        if (mode) begin
                            state_q  <= S_HAD;
                            crl_q    <= CRL_HAD;
                            had_rd_q <= 1'b1;
                        end else if (vec_len != '0) begin
                            state_q   <= S_MAC;
                            crl_q     <= CRL_MAC;
                            addr_q    <= '0;
                            spad_rd_q <= 1'b1;
                        end else begin
                            state_q <= S_SHIFT;
                            valid_q <= 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    if (cnt_q == len_q) begin
                        state_q   <= S_SHIFT;
                        cnt_q     <= '0;
                        spad_rd_q <= 1'b0;
                        valid_q   <= 1'b1;
                        scnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_d[ADDR_W-1:0];
                        // Drain cycle keeps the last address and drops the strobe.
                        if (cnt_d < {1'b0, len_q}) begin
                            addr_q    <= cnt_d[ADDR_W-1:0];
                            spad_rd_q <= 1'b1;
                        end else begin
                            spad_rd_q <= 1'b0;
                        end
                    end
                end
                S_HAD: begin
                    if (cnt_q == '0) begin
                        cnt_q    <= {{(ADDR_W-1){1'b0}}, 1'b1};
                        had_rd_q <= 1'b0;
                    end else begin
                        state_q <= S_SHIFT;
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        scnt_q  <= '0;
                    end
                end
                S_SHIFT: begin
                    if (res_ready) begin
                        if (scnt_q == SCNT_LAST) begin
                            state_q <= S_CLR;
                            scnt_q  <= '0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            crl_q   <= CRL_RST;
                        end else begin
                            scnt_q <= scnt_q + 1'b1;
                        end
                    end
                end
                S_CLR: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    crl_q   <= CRL_RST;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Shifting follows res_ready in the same cycle so an accept never costs a bubble.
    assign mult_int8_crl = (state_q == S_SHIFT) ? (res_ready ? CRL_XFER : CRL_HOLD) : crl_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign spad_addr     = addr_q;
    assign spad_rd_en    = spad_rd_q;
    assign had_rd_en     = had_rd_q;
    assign res_valid     = valid_q;
    assign res_data      = tail_out;

endmodule
`default_nettype wire

// File: tb/tb_pe_row_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_pe_row_ctrl: directed bench with a behavioural PE row and scoreboard |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_pe_row_ctrl;
    localparam int NUM_PE = 4;
    localparam int ADDR_W = 8;
    localparam int DW     = 32;

    localparam logic [2:0] MAC_CRL [9] = '{3'b001, 3'b001, 3'b001, 3'b001,
                                           3'b011, 3'b011, 3'b011, 3'b011, 3'b000};
    localparam logic [7:0] MAC_ADR [4] = '{8'd0, 8'd1, 8'd2, 8'd2};
    localparam logic [2:0] HAD_CRL [7] = '{3'b010, 3'b010, 3'b011, 3'b011,
                                           3'b011, 3'b011, 3'b000};
    localparam logic [2:0] BP_CRL  [9] = '{3'b010, 3'b010, 3'b011, 3'b111, 3'b111,
                                           3'b011, 3'b011, 3'b011, 3'b000};
    localparam logic       BP_RDY  [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                                           1'b1, 1'b1, 1'b1, 1'b1};
    localparam logic [2:0] M2_CRL  [8] = '{3'b001, 3'b001, 3'b001, 3'b011,
                                           3'b011, 3'b011, 3'b011, 3'b000};

    logic              wclk = 1'b0;
    logic              rst_n;
    logic [3:0]        seg_state;
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] vec_len;
    logic              busy;
    logic              done;
    logic [2:0]        crl;
    logic [ADDR_W-1:0] spad_addr;
    logic              spad_rd_en;
    logic              had_rd_en;
    logic [DW-1:0]     tail_out;
    logic [DW-1:0]     res_data;
    logic              res_valid;
    logic              res_ready;

    always #5 wclk = ~wclk;

    pe_row_ctrl #(.NUM_PE(NUM_PE), .ADDR_W(ADDR_W), .OUT_BQ_DW(DW)) dut (
        .wclk(wclk), .rst_n(rst_n), .seg_state(seg_state), .start(start),
        .mode(mode), .vec_len(vec_len), .busy(busy), .done(done),
        .mult_int8_crl(crl), .spad_addr(spad_addr), .spad_rd_en(spad_rd_en),
        .had_rd_en(had_rd_en), .tail_out(tail_out), .res_data(res_data),
        .res_valid(res_valid), .res_ready(res_ready)
    );

    // Behavioural PE row: operand register stage feeding a 32-bit accumulator.
    logic signed [7:0]  w_mem [NUM_PE][16];
    logic signed [7:0]  a_mem [NUM_PE][16];
    logic signed [7:0]  ha [NUM_PE];
    logic signed [7:0]  hb [NUM_PE];
    logic signed [7:0]  opx [NUM_PE];
    logic signed [7:0]  opy [NUM_PE];
    logic signed [31:0] acc [NUM_PE];

    function automatic logic signed [31:0] mul(input logic signed [7:0] x, input logic signed [7:0] y);
        logic signed [31:0] xx;
        logic signed [31:0] yy;
        xx = x;
        yy = y;
        return xx * yy;
    endfunction

    assign tail_out = acc[0];

    always @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PE; p++) begin
                acc[p] <= 0; opx[p] <= 0; opy[p] <= 0;
            end
        end else begin
            for (int p = 0; p < NUM_PE; p++) begin
                case (crl)
                    3'b000: begin acc[p] <= 0; opx[p] <= 0; opy[p] <= 0; end
                    3'b001: begin
                        opx[p] <= spad_rd_en ? w_mem[p][spad_addr[3:0]] : 8'sd0;
                        opy[p] <= spad_rd_en ? a_mem[p][spad_addr[3:0]] : 8'sd0;
                        acc[p] <= acc[p] + mul(opx[p], opy[p]);
                    end
                    3'b010: begin
                        opx[p] <= had_rd_en ? ha[p] : 8'sd0;
                        opy[p] <= had_rd_en ? hb[p] : 8'sd0;
                        acc[p] <= mul(opx[p], opy[p]);
                    end
                    3'b011: acc[p] <= (p < NUM_PE - 1) ? acc[(p + 1) % NUM_PE] : 32'sd0;
                    default: ;
                endcase
            end
        end
    end

    logic [DW-1:0] sb [$];
    int n_checks = 0;
    int n_err    = 0;
    int n_acc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every accepted word is popped from the scoreboard and compared.
    always @(negedge wclk) begin
        #2;
        if (rst_n && res_valid && res_ready) begin
            n_checks++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL sb_underflow observed=%0h expected=queued_word", res_data);
            end
            if (sb.size() != 0) chk("res_data", res_data, sb.pop_front());
            n_acc++;
        end
    end

    task automatic nxt();
        @(negedge wclk);
    endtask

    task automatic kick(input logic m, input logic [7:0] len);
        nxt();
        start   = 1'b1;
        mode    = m;
        vec_len = len;
        nxt();
        start   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; seg_state = 4'b0010; start = 1'b0; mode = 1'b0;
        vec_len = '0; res_ready = 1'b1;
        for (int p = 0; p < NUM_PE; p++) begin
            ha[p] = 0; hb[p] = 0;
            for (int k = 0; k < 16; k++) begin w_mem[p][k] = 0; a_mem[p][k] = 0; end
        end
        nxt(); nxt(); #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_crl", 32'(crl), 0);
        chk("rst_addr", 32'(spad_addr), 0);
        chk("rst_rd", 32'({spad_rd_en, had_rd_en, res_valid}), 0);
        nxt(); rst_n = 1'b1;

        // Gate MAC, vec_len=3, w=a=2 everywhere
        for (int p = 0; p < NUM_PE; p++)
            for (int k = 0; k < 3; k++) begin w_mem[p][k] = 2; a_mem[p][k] = 2; end
        repeat (NUM_PE) sb.push_back(32'd12);
        kick(1'b0, 8'd3);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) nxt();
            #1;
            chk("mac_crl", 32'(crl), 32'(MAC_CRL[i]));
            chk("mac_done", 32'(done), 32'(i == 8));
            chk("mac_busy", 32'(busy), 1);
            if (i < 4) begin
                chk("mac_addr", 32'(spad_addr), 32'(MAC_ADR[i]));
                chk("mac_rd", 32'(spad_rd_en), 32'(i < 3));
            end
        end
        nxt(); #1;
        chk("mac_end_busy", 32'(busy), 0);
        chk("mac_sb_empty", sb.size(), 0);

        // Hadamard, a=-3 b=5
        for (int p = 0; p < NUM_PE; p++) begin ha[p] = -3; hb[p] = 5; end
        repeat (NUM_PE) sb.push_back(32'hFFFF_FFF1);
        kick(1'b1, 8'd0);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) nxt();
            #1;
            chk("had_crl", 32'(crl), 32'(HAD_CRL[i]));
            chk("had_rd", 32'(had_rd_en), 32'(i == 0));
            chk("had_done", 32'(done), 32'(i == 6));
        end
        nxt(); #1;
        chk("had_sb_empty", sb.size(), 0);

        // Backpressure with distinct per-PE products
        for (int p = 0; p < NUM_PE; p++) begin ha[p] = 8'(p + 1); hb[p] = 7; end
        for (int p = 0; p < NUM_PE; p++) sb.push_back(32'(7 * (p + 1)));
        kick(1'b1, 8'd0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) nxt();
            res_ready = BP_RDY[i];
            #1;
            chk("bp_crl", 32'(crl), 32'(BP_CRL[i]));
            chk("bp_done", 32'(done), 32'(i == 8));
            if (!BP_RDY[i]) begin
                chk("bp_valid", 32'(res_valid), 1);
                chk("bp_hold_data", res_data, (sb.size() != 0) ? sb[0] : 32'hDEAD_BEEF);
            end
        end
        res_ready = 1'b1;
        nxt(); #1;
        chk("bp_sb_empty", sb.size(), 0);

        // vec_len = 0 gate MAC: straight to SHIFT with zero results
        repeat (NUM_PE) sb.push_back(32'd0);
        kick(1'b0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) nxt();
            #1;
            chk("z_crl", 32'(crl), (i < 4) ? 32'd3 : 32'd0);
            chk("z_rd", 32'(spad_rd_en), 0);
            chk("z_done", 32'(done), 32'(i == 4));
        end
        nxt(); #1;
        chk("z_sb_empty", sb.size(), 0);

        // Abort mid-MAC; start while busy and start with wrong seg_state ignored
        for (int p = 0; p < NUM_PE; p++)
            for (int k = 0; k < 10; k++) begin w_mem[p][k] = 1; a_mem[p][k] = 1; end
        kick(1'b0, 8'd10);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) nxt();
            if (i == 3) begin start = 1'b1; mode = 1'b1; end
            if (i == 4) begin start = 1'b0; seg_state = 4'b0100; end
            #1;
            chk("ab_crl", 32'(crl), 32'd1);
            chk("ab_addr", 32'(spad_addr), 32'(i));
        end
        nxt(); #1;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_crl_idle", 32'(crl), 0);
        chk("ab_done", 32'(done), 0);
        chk("ab_rd", 32'(spad_rd_en), 0);
        nxt(); start = 1'b1; mode = 1'b0; vec_len = 8'd3; #1;
        chk("ab_done2", 32'(done), 0);
        nxt(); start = 1'b0; #1;
        chk("segoff_busy", 32'(busy), 0);
        chk("segoff_crl", 32'(crl), 0);
        seg_state = 4'b0010;

        // Reset asserted in the middle of SHIFT
        for (int p = 0; p < NUM_PE; p++) begin ha[p] = 8'(p + 1); hb[p] = -2; end
        for (int p = 0; p < NUM_PE; p++) sb.push_back(32'(-2 * (p + 1)));
        kick(1'b1, 8'd0);
        nxt(); nxt(); nxt();
        nxt(); rst_n = 1'b0; #1;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_done", 32'(done), 0);
        chk("mr_crl", 32'(crl), 0);
        chk("mr_addr", 32'(spad_addr), 0);
        chk("mr_rd", 32'({spad_rd_en, had_rd_en, res_valid}), 0);
        chk("mr_sb_left", sb.size(), 2);
        sb.delete();
        nxt(); nxt(); rst_n = 1'b1;

        // Fresh gate MAC after reset, vec_len=2, per-PE weights
        for (int p = 0; p < NUM_PE; p++)
            for (int k = 0; k < 2; k++) begin w_mem[p][k] = 8'(p + 1); a_mem[p][k] = 8'(k + 1); end
        for (int p = 0; p < NUM_PE; p++) sb.push_back(32'(3 * (p + 1)));
        kick(1'b0, 8'd2);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) nxt();
            #1;
            chk("m2_crl", 32'(crl), 32'(M2_CRL[i]));
            chk("m2_done", 32'(done), 32'(i == 7));
            if (i < 3) begin
                chk("m2_addr", 32'(spad_addr), (i == 0) ? 32'd0 : 32'd1);
                chk("m2_rd", 32'(spad_rd_en), 32'(i < 2));
            end
        end
        nxt(); #1;
        chk("m2_sb_empty", sb.size(), 0);
        chk("accepted_words", n_acc, 22);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
